// File: rtl/sum_block_accumulator.sv
// sum_block_accumulator
//
// Takes the 8-bit sums from the adder stage and collects them into blocks of
// BLOCK_LEN samples. Each block produces a saturating total, an average
// (total >> log2(BLOCK_LEN)) and a flag that says whether the total clamped.
// The result is offered on a valid/ready port. A wrapping counter records how
// many results the consumer has taken.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, has priority over everything
//   clear       synchronous abort of the block in progress or of a pending result
//   in_valid    a sample is present on in_data
//   in_ready    the block can take a sample this cycle (combinational)
//   in_data     sum sample from the adder stage
//   out_valid   a block result is available
//   out_ready   the consumer takes the result this cycle
//   out_total   saturated block total
//   out_avg     out_total >> log2(BLOCK_LEN), low DATA_W bits
//   out_sat     the total saturated during this block
//   blocks_done count of results taken, wraps 255 -> 0
//
// DATA_W must not exceed ACC_W. BLOCK_LEN must be a power of two, 2..128.

module sum_block_accumulator #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 10,
    parameter int BLOCK_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [DATA_W-1:0] out_avg,
    output logic              out_sat,
    output logic [7:0]        blocks_done
);

    localparam int SHIFT = $clog2(BLOCK_LEN);
    localparam int CNT_W = SHIFT;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             sat;

    logic [SUM_W-1:0] sum_wide;
    logic [ACC_W-1:0] next_acc;
    logic             next_sat;
    logic             accept;

    // clear blocks acceptance in the same cycle, so an aborted block never
    // swallows the sample that was on the bus when it was aborted.
    assign in_ready = (state == ACCUM) && !clear;
    assign accept   = in_valid && in_ready;

    // The sum is formed one bit wider than the accumulator. The carry bit then
    // shows directly whether the unclamped sum went past ACC_MAX.
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        sum_wide = {1'b0, acc} + SUM_W'(in_data);
        next_acc = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
        next_sat = sat | sum_wide[ACC_W];
    end

    // NOTE: state is written with non-blocking assignments, so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            acc         <= '0;
            count       <= '0;
            sat         <= 1'b0;
            out_valid   <= 1'b0;
            out_total   <= '0;
            out_avg     <= '0;
            out_sat     <= 1'b0;
            blocks_done <= 8'd0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clear) begin
                        acc   <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                    end else if (accept) begin
                        if (count == LAST_IDX) begin
                            // The last sample goes straight into the result
                            // registers. The accumulator restarts clean, so the
                            // sticky flag never leaks into the next block.
                            out_total <= next_acc;
                            out_avg   <= DATA_W'(next_acc >> SHIFT);
                            out_sat   <= next_sat;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                            acc       <= '0;
                            count     <= '0;
                            sat       <= 1'b0;
                        end else begin
                            acc   <= next_acc;
                            count <= count + 1'b1;
                            sat   <= next_sat;
                        end
                    end
                end

                HOLD: begin
                    // clear wins over a same-cycle handshake. The abandoned
                    // result is therefore not counted as delivered.
                    if (clear) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end else if (out_valid && out_ready) begin
                        out_valid   <= 1'b0;
                        blocks_done <= blocks_done + 8'd1;
                        state       <= ACCUM;
                    end
                end

                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Self-checking bench for sum_block_accumulator (DATA_W=8, ACC_W=10, BLOCK_LEN=8).
// A behavioural model tracks the accumulator and the handshakes. Each block
// result is pushed into a scoreboard when its last sample is driven. The
// result is popped and compared when out_valid rises.

module tb_sum_block_accumulator;

    localparam int ACC_MAX = 1023;
    localparam int BLK     = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_total;
    logic [7:0] out_avg;
    logic       out_sat;
    logic [7:0] blocks_done;

    sum_block_accumulator #(
        .DATA_W    (8),
        .ACC_W     (10),
        .BLOCK_LEN (BLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_total   (out_total),
        .out_avg     (out_avg),
        .out_sat     (out_sat),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int total;
        int avg;
        int sat;
    } res_t;

    res_t sb[$];
    res_t cur;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    bit m_hold   = 1'b0;
    int m_acc    = 0;
    int m_cnt    = 0;
    bit m_sat    = 1'b0;
    int m_blocks = 0;
    int m_hs     = 0;
    bit prev_ov  = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Applies one rising edge to the model, using the inputs driven for that edge.
    task automatic model_edge(input bit r, input bit iv, input int d, input bit ordy, input bit clr);
        int s;
        if (r) begin
            m_hold = 0; m_acc = 0; m_cnt = 0; m_sat = 0; m_blocks = 0;
            sb.delete();
        end else if (!m_hold) begin
            if (clr) begin
                m_acc = 0; m_cnt = 0; m_sat = 0;
            end else if (iv) begin
                s = m_acc + d;
                if (s > ACC_MAX) begin
                    s = ACC_MAX;
                    m_sat = 1;
                end
                m_acc = s;
                m_cnt++;
                if (m_cnt == BLK) begin
                    sb.push_back('{m_acc, m_acc / BLK, int'(m_sat)});
                    m_hold = 1; m_acc = 0; m_cnt = 0; m_sat = 0;
                end
            end
        end else begin
            if (clr) begin
                m_hold = 0;
            end else if (ordy) begin
                m_hold = 0;
                m_blocks = (m_blocks + 1) % 256;
                m_hs++;
            end
        end
    endtask

    // One clock cycle: drive the inputs, check in_ready, take the edge, then check the outputs.
    task automatic cycle(input bit r, input bit iv, input int d, input bit ordy, input bit clr);
        rst = r; in_valid = iv; in_data = 8'(d); out_ready = ordy; clear = clr;
        #1;
        if (!r) check("in_ready", int'(in_ready), int'(!m_hold && !clr));
        @(posedge clk);
        model_edge(r, iv, d, ordy, clr);
        #1;
        check("out_valid", int'(out_valid), int'(m_hold));
        check("blocks_done", int'(blocks_done), m_blocks);
        if (r) begin
            cur = '{0, 0, 0};
            check("rst_total", int'(out_total), 0);
            check("rst_avg", int'(out_avg), 0);
            check("rst_sat", int'(out_sat), 0);
        end else begin
            if (out_valid && !prev_ov) begin
                check("sb_depth", sb.size(), 1);
                if (sb.size() > 0) cur = sb.pop_front();
            end
            if (out_valid) begin
                check("total", int'(out_total), cur.total);
                check("avg", int'(out_avg), cur.avg);
                check("sat", int'(out_sat), cur.sat);
            end
        end
        prev_ov = out_valid;
    endtask

    task automatic block_of(input int v);
        for (int i = 0; i < BLK; i++) cycle(0, 1, v, 0, 0);
    endtask

    task automatic release_result();
        cycle(0, 1, 77, 1, 0);
    endtask

    initial begin
        int bd;
        int hs0;
        int budget;
        bit iv;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Ramp 10..80
        for (int i = 1; i <= BLK; i++) cycle(0, 1, 10 * i, 0, 0);
        check("t1_total", int'(out_total), 360);
        check("t1_avg", int'(out_avg), 45);
        check("t1_sat", int'(out_sat), 0);
        release_result();
        check("t1_blocks", int'(blocks_done), 1);

        // Saturation, then the sticky flag must not carry over
        block_of(255);
        check("t2_total", int'(out_total), 1023);
        check("t2_avg", int'(out_avg), 127);
        check("t2_sat", int'(out_sat), 1);
        release_result();
        block_of(1);
        check("t2b_total", int'(out_total), 8);
        check("t2b_sat", int'(out_sat), 0);
        release_result();

        // Backpressure: the result is held and no samples are consumed
        block_of(3);
        for (int i = 0; i < 5; i++) cycle(0, 1, 99, 0, 0);
        check("t3_hold_total", int'(out_total), 24);
        cycle(0, 1, 99, 1, 0);
        check("t3_blocks", int'(blocks_done), 4);
        block_of(4);
        check("t3b_total", int'(out_total), 32);
        release_result();

        // clear in ACCUM, then clear in HOLD
        for (int i = 0; i < 3; i++) cycle(0, 1, 100, 0, 0);
        cycle(0, 1, 100, 0, 1);
        block_of(2);
        check("t4_total", int'(out_total), 16);
        release_result();
        bd = int'(blocks_done);
        block_of(7);
        cycle(0, 0, 0, 1, 1);
        check("t4_clr_valid", int'(out_valid), 0);
        check("t4_clr_blocks", int'(blocks_done), bd);

        // Reset mid-block and during HOLD
        for (int i = 0; i < 5; i++) cycle(0, 1, 9, 0, 0);
        cycle(1, 1, 9, 0, 0);
        block_of(9);
        cycle(1, 1, 9, 1, 0);
        block_of(5);
        check("t5_total", int'(out_total), 40);
        release_result();

        // 256 random blocks with gaps and random backpressure
        bd = int'(blocks_done);
        hs0 = m_hs;
        budget = 20000;
        while ((m_hs - hs0) < 256 && budget > 0) begin
            iv = ($urandom_range(0, 3) != 0);
            cycle(0, iv, int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 0);
            budget--;
        end
        check("rand_blocks", m_hs - hs0, 256);
        check("rand_wrap", int'(blocks_done), bd);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
